serial_addsub: RTL and testbench
================================

// Module: serial_addsub
// PURPOSE
//   Parametrised bit-serial adder/subtractor, LSB first, one full-adder slice per clock.
//   Generalises the 4-bit serial adder to WIDTH bits and adds subtract mode.
//   Adds a start/busy/done handshake and a signed-overflow flag.
//   Sits in the datapath as an area-cheap arithmetic unit fed by a controller FSM.
// PARAMETERS
//   WIDTH  4  operand/result width in bits (legal: WIDTH >= 2)
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-low (0 = reset)
//   start      in   1      request; sampled only in IDLE
//   sub        in   1      0 = a+b, 1 = a-b; sampled with start
//   in_a       in   WIDTH  operand A; sampled with start
//   in_b       in   WIDTH  operand B; sampled with start
//   busy       out  1      1 while an operation is in progress
//   done       out  1      1-cycle pulse: result outputs updated this cycle
//   sum_out    out  WIDTH  result, held until the next completion
//   carry_out  out  1      carry out of MSB (sub: 1 = no borrow, i.e. a >= b unsigned)
//   overflow   out  1      two's-complement overflow (carry into MSB ^ carry out of MSB)
// BEHAVIOUR
//   Reset (rst=0, async): state IDLE; busy, done, sum_out, carry_out, overflow,
//     bit counter, operand/result shift registers and carry FF all 0.
//   FSM states: IDLE, SHIFT.
//   IDLE: start=1 at edge E0 -> load A shift reg = in_a, B shift reg = in_b ^ {WIDTH{sub}},
//     carry FF = sub, counter = 0; go SHIFT; busy=1 from E0.
//   SHIFT: each edge computes s = a[0]^b[0]^c, c' = maj(a[0],b[0],c); shift A/B right;
//     shift s into result MSB; counter++. Edges E1..E(WIDTH) process bits 0..WIDTH-1.
//   At edge E(WIDTH) (counter = WIDTH-1): sum_out <= full result, carry_out <= c',
//     overflow <= c ^ c' (c = carry into MSB), done <= 1, busy <= 0, go IDLE.
//   Latency: done high exactly WIDTH edges after the accepting edge; done clears next edge.
//   Throughput: new start accepted at the edge where done is visible (state IDLE),
//     so start held high gives one result every WIDTH+1 cycles.
//   start while busy: ignored, no queueing. in_a/in_b/sub changes while busy: ignored.
//   sum_out/carry_out/overflow change only at completion; not cleared by start.
//   Counter width $clog2(WIDTH); wraps never (reset to 0 on accept).
//   Arithmetic is modulo 2^WIDTH; no saturation.
//   Reset mid-operation: abort immediately, all outputs to reset values, no done pulse;
//     first start after rst returns high is processed normally.
// TESTING
//   T1 WIDTH=4, reset then add 0000+0011 -> sum_out=0011 carry_out=0 overflow=0,
//      done exactly 4 edges after accepting edge, busy high for those 4 cycles.
//   T2 WIDTH=4 add: 1111+1111 -> 1110 c=1 ovf=0; 1000+1001 -> 0001 c=1 ovf=1;
//      1100+0011 -> 1111 c=0 ovf=0.
//   T3 WIDTH=4 sub: 0011-0011 -> 0000 c=1 ovf=0; 0001-1011 -> 0110 c=0 ovf=0;
//      1000-0001 -> 0111 c=1 ovf=1.
//   T4 Start 0001+0001, then pulse start and change in_a/in_b/sub during busy ->
//      single done, sum_out=0010; second start produces no extra done.
//   T5 Start 1111+0001, drive rst=0 on 2nd busy cycle -> all outputs 0 at once, no done;
//      after rst=1, 0010+0011 -> 0101, done after 4 edges.
//   T6 WIDTH=8: 0xFF+0x01 -> 0x00 c=1 ovf=0, done after 8 edges; start held high for
//      two ops (0x7F+0x01 -> 0x80 ovf=1) -> done pulses 9 cycles apart.

Source files
------------

// File: rtl/serial_addsub_if.sv
// serial_addsub_if: request/result bundle for the bit-serial adder/subtractor.
//   start, sub, in_a, in_b         : request, driven by the controller (master)
//   busy, done, sum_out,
//   carry_out, overflow            : status/result, driven by the unit (slave)
interface serial_addsub_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, sub, in_a, in_b,
    input  busy, done, sum_out, carry_out, overflow
  );

  modport slave (
    input  start, sub, in_a, in_b,
    output busy, done, sum_out, carry_out, overflow
  );
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial WIDTH-bit adder/subtractor, LSB first, one
// full-adder slice per clock.
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active low
//   bus  : serial_addsub_if.slave
//          start/sub/in_a/in_b sampled only when idle;
//          busy high while shifting, done pulses once when sum_out,
//          carry_out and overflow are updated (held until next completion).
// Subtraction is a + ~b + 1: B is inverted on load and the carry FF is
// seeded with sub. carry_out is therefore "no borrow" in subtract mode.
module serial_addsub #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  serial_addsub_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             cy;
  logic [CW-1:0]    cnt;

  // one full-adder slice on the current LSBs
  logic s_bit, c_nxt;
  logic [WIDTH-1:0] res_nxt;
  assign s_bit   = a_sr[0] ^ b_sr[0] ^ cy;
  assign c_nxt   = (a_sr[0] & b_sr[0]) | (a_sr[0] & cy) | (b_sr[0] & cy);
  assign res_nxt = {s_bit, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      a_sr          <= '0;
      b_sr          <= '0;
      res_sr        <= '0;
      cy            <= 1'b0;
      cnt           <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.sum_out   <= '0;
      bus.carry_out <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr     <= bus.in_a;
            b_sr     <= bus.in_b ^ {WIDTH{bus.sub}};
            cy       <= bus.sub;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nxt;
          cy     <= c_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            // cy here is the carry into the MSB slice
            bus.sum_out   <= res_nxt;
            bus.carry_out <= c_nxt;
            bus.overflow  <= cy ^ c_nxt;
            bus.done      <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst4, rst8;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_addsub_if #(.WIDTH(4)) if4 ();
  serial_addsub_if #(.WIDTH(8)) if8 ();

  serial_addsub #(.WIDTH(4)) u4 (.clk(clk), .rst(rst4), .bus(if4));
  serial_addsub #(.WIDTH(8)) u8 (.clk(clk), .rst(rst8), .bus(if8));

  typedef struct {
    logic [7:0] sum;
    logic       c;
    logic       ov;
    int         at;   // cycle stamp at which done must be visible
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push4(input logic [3:0] s, input logic c, input logic ov, input int lat);
    exp_t e;
    e.sum = {4'h0, s}; e.c = c; e.ov = ov; e.at = cyc + 1 + lat;
    q4.push_back(e);
  endtask

  task automatic push8(input logic [7:0] s, input logic c, input logic ov, input int at);
    exp_t e;
    e.sum = s; e.c = c; e.ov = ov; e.at = at;
    q8.push_back(e);
  endtask

  task automatic wait_q4();
    for (int i = 0; i < 40 && q4.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (q4.size() != 0) begin
      n_tot++;
      $display("FAIL timeout4: %0d results outstanding, expected 0", q4.size());
      q4.delete();
    end
  endtask

  task automatic wait_q8();
    for (int i = 0; i < 60 && q8.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (q8.size() != 0) begin
      n_tot++;
      $display("FAIL timeout8: %0d results outstanding, expected 0", q8.size());
      q8.delete();
    end
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s,
                      input logic [3:0] es, input logic ec, input logic eo);
    @(negedge clk);
    if4.start = 1'b1; if4.in_a = a; if4.in_b = b; if4.sub = s;
    push4(es, ec, eo, 4);
    @(negedge clk);
    if4.start = 1'b0;
    wait_q4();
  endtask

  initial begin
    exp_t e;
    rst4 = 1'b0; rst8 = 1'b0;
    if4.start = 1'b0; if4.sub = 1'b0; if4.in_a = '0; if4.in_b = '0;
    if8.start = 1'b0; if8.sub = 1'b0; if8.in_a = '0; if8.in_b = '0;

    // scoreboard monitor: pops on every done and checks value and latency
    fork
      forever begin
        @(negedge clk);
        if (if4.done === 1'b1) begin
          if (q4.size() == 0) begin
            n_tot++;
            $display("FAIL extra_done4: done=1 expected no result, sum %0h", if4.sum_out);
          end else begin
            e = q4.pop_front();
            chk("res4", {23'd0, if4.carry_out, if4.overflow, 4'h0, if4.sum_out},
                        {23'd0, e.c, e.ov, e.sum});
            chk("lat4", cyc, e.at);
          end
        end
        if (if8.done === 1'b1) begin
          if (q8.size() == 0) begin
            n_tot++;
            $display("FAIL extra_done8: done=1 expected no result, sum %0h", if8.sum_out);
          end else begin
            e = q8.pop_front();
            chk("res8", {22'd0, if8.carry_out, if8.overflow, if8.sum_out},
                        {22'd0, e.c, e.ov, e.sum});
            chk("lat8", cyc, e.at);
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk("rst4", {if4.busy, if4.done, if4.carry_out, if4.overflow, if4.sum_out}, 0);
    chk("rst8", {if8.busy, if8.done, if8.carry_out, if8.overflow, if8.sum_out}, 0);
    rst4 = 1'b1; rst8 = 1'b1;

    // T1: 0000+0011, busy for exactly 4 cycles
    @(negedge clk);
    if4.start = 1'b1; if4.in_a = 4'b0000; if4.in_b = 4'b0011; if4.sub = 1'b0;
    push4(4'b0011, 1'b0, 1'b0, 4);
    @(negedge clk);
    if4.start = 1'b0;
    chk("t1_busy0", {31'd0, if4.busy}, 1);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("t1_busy", {31'd0, if4.busy}, 1);
    end
    @(negedge clk);
    chk("t1_busy_end", {30'd0, if4.busy, if4.done}, 1);
    wait_q4();

    // T2: add
    run4(4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0);
    run4(4'b1000, 4'b1001, 1'b0, 4'b0001, 1'b1, 1'b1);
    run4(4'b1100, 4'b0011, 1'b0, 4'b1111, 1'b0, 1'b0);

    // T3: subtract
    run4(4'b0011, 4'b0011, 1'b1, 4'b0000, 1'b1, 1'b0);
    run4(4'b0001, 4'b1011, 1'b1, 4'b0110, 1'b0, 1'b0);
    run4(4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1);

    // T4: start and operand changes while busy are ignored
    @(negedge clk);
    if4.start = 1'b1; if4.in_a = 4'b0001; if4.in_b = 4'b0001; if4.sub = 1'b0;
    push4(4'b0010, 1'b0, 1'b0, 4);
    @(negedge clk);
    if4.start = 1'b0;
    @(negedge clk);
    if4.start = 1'b1; if4.in_a = 4'b1111; if4.in_b = 4'b1111; if4.sub = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    wait_q4();
    repeat (6) @(negedge clk);

    // T5: reset mid-operation aborts with no done
    @(negedge clk);
    if4.start = 1'b1; if4.in_a = 4'b1111; if4.in_b = 4'b0001; if4.sub = 1'b0;
    @(negedge clk);
    if4.start = 1'b0;
    @(negedge clk);
    rst4 = 1'b0;
    #1;
    chk("t5_rst", {if4.busy, if4.done, if4.carry_out, if4.overflow, if4.sum_out}, 0);
    @(negedge clk);
    rst4 = 1'b1;
    repeat (6) @(negedge clk);
    chk("t5_idle", {if4.busy, if4.done, if4.carry_out, if4.overflow, if4.sum_out}, 0);
    run4(4'b0010, 4'b0011, 1'b0, 4'b0101, 1'b0, 1'b0);

    // T6: WIDTH=8
    @(negedge clk);
    if8.start = 1'b1; if8.in_a = 8'hFF; if8.in_b = 8'h01; if8.sub = 1'b0;
    push8(8'h00, 1'b1, 1'b0, cyc + 9);
    @(negedge clk);
    if8.start = 1'b0;
    wait_q8();

    // start held high: back-to-back ops, done pulses 9 cycles apart
    @(negedge clk);
    if8.start = 1'b1; if8.in_a = 8'h7F; if8.in_b = 8'h01; if8.sub = 1'b0;
    push8(8'h80, 1'b0, 1'b1, cyc + 9);
    push8(8'h80, 1'b0, 1'b1, cyc + 18);
    repeat (18) @(negedge clk);
    if8.start = 1'b0;
    wait_q8();
    repeat (12) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
